pipelined_alu: RTL and testbench

//  Parametrised, two-stage pipelined successor of the Mini ALU output mux.

---
 rtl/pipelined_alu.sv | 167 ++++++++++++++++
 tb/tb_pipelined_alu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// ============================================================================
//  Module   : pipelined_alu
//  Brief    : Two-stage valid/ready ALU with Z/C/V flags and a completed-op
//             counter. Define ALU_SAT_EN to saturate add/sub on overflow.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_alu #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fxn_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;
`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_fxn_q,   s1_fxn_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             flag_z_q,   flag_z_d;
    logic             flag_c_q,   flag_c_d;
    logic             flag_v_q,   flag_v_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;

    // Subtract reuses the adder as a + ~b + 1; borrow is the inverted carry.
    always_comb begin
        w_is_sub  = s1_fxn_q[0];
        w_b_op    = w_is_sub ? ~s1_b_q : s1_b_q;
        w_sum     = {1'b0, s1_a_q} + {1'b0, w_b_op} + (WIDTH+1)'(w_is_sub);
        w_ovf     = (s1_a_q[WIDTH-1] == w_b_op[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
        w_alu_res = c_zero;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (s1_fxn_q)
            3'b000: w_alu_res = s1_a_q;
            3'b001: w_alu_res = s1_b_q;
            3'b010: w_alu_res = ~s1_a_q + c_one;
            3'b011: w_alu_res = ~s1_b_q + c_one;
            3'b100: w_alu_res = {{(WIDTH-1){1'b0}}, (s1_a_q > s1_b_q)};
            3'b101: w_alu_res = s1_a_q ^ s1_b_q;
            default: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_is_sub ? ~w_sum[WIDTH] : w_sum[WIDTH];
                w_alu_v   = w_ovf;
`ifdef ALU_SAT_EN
                // Overflow direction follows a's sign: positive a can only overflow upward.
                if (w_ovf) begin
                    w_alu_res = s1_a_q[WIDTH-1] ? c_sat_min : c_sat_max;
                end
`endif
            end
        endcase
    end

    always_comb begin
        w_s2_adv   = !out_valid_q || out_ready;
        w_in_ready = !s1_valid_q || w_s2_adv;
        w_in_fire  = in_valid && w_in_ready;
        w_out_fire = out_valid_q && out_ready;

        s1_valid_d  = s1_valid_q;
        s1_fxn_d    = s1_fxn_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        op_count_d  = op_count_q;

        if (w_in_fire) begin
            s1_valid_d = 1'b1;
            s1_fxn_d   = fxn_code;
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (w_s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (w_s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = w_alu_res;
                flag_z_d = (w_alu_res == c_zero);
                flag_c_d = w_alu_c;
                flag_v_d = w_alu_v;
            end
        end

        if (w_out_fire) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_fxn_q    <= 3'b000;
            s1_a_q      <= c_zero;
            s1_b_q      <= c_zero;
            out_valid_q <= 1'b0;
            result_q    <= c_zero;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fxn_q    <= s1_fxn_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign op_count  = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_alu.sv
// ============================================================================
//  Module   : tb_pipelined_alu
//  Brief    : Directed self-checking bench for pipelined_alu (WIDTH=6), with a
//             CNT_W=2 twin sharing the same stimulus for counter wrap.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_alu;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] fxn_code;
    logic [5:0] a;
    logic [5:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] result;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic [7:0] op_count;

    logic       in_ready2;
    logic       out_valid2;
    logic [5:0] result2;
    logic       flag_z2;
    logic       flag_c2;
    logic       flag_v2;
    logic [1:0] op_count2;

    int n_cmp = 0;
    int n_err = 0;

    pipelined_alu #(.WIDTH(6), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .fxn_code(fxn_code), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .op_count(op_count)
    );

    pipelined_alu #(.WIDTH(6), .CNT_W(2)) dut_cnt2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .fxn_code(fxn_code), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .flag_z(flag_z2), .flag_c(flag_c2), .flag_v(flag_v2),
        .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated beat through an idle pipeline; called at posedge+1.
    task automatic op(input string tag, input logic [2:0] f, input logic [5:0] av,
                      input logic [5:0] bv, input logic [5:0] er,
                      input logic ez, input logic ec, input logic ev);
        fxn_code  = f;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_ov_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_zcv"}, 32'({flag_z, flag_c, flag_v}), 32'({ez, ec, ev}));
        @(posedge clk); #1;
    endtask

    logic [8:0] stream_exp [8];
    logic [5:0] held;
    logic [5:0] sat_pos;
    logic [5:0] sat_neg;
    int sent;
    int recv;

    initial begin
`ifdef ALU_SAT_EN
        sat_pos = 6'h1F;
        sat_neg = 6'h20;
`else
        sat_pos = 6'h20;
        sat_neg = 6'h1F;
`endif
        // {result, z, c, v} for a=12, b=5 under codes 000..111
        stream_exp[0] = {6'h0C, 3'b000};
        stream_exp[1] = {6'h05, 3'b000};
        stream_exp[2] = {6'h34, 3'b000};
        stream_exp[3] = {6'h3B, 3'b000};
        stream_exp[4] = {6'h01, 3'b000};
        stream_exp[5] = {6'h09, 3'b000};
        stream_exp[6] = {6'h11, 3'b000};
        stream_exp[7] = {6'h07, 3'b000};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fxn_code  = 3'b000;
        a         = 6'h00;
        b         = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({result, flag_z, flag_c, flag_v}), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;

        op("add_5_3", 3'b110, 6'd5, 6'd3, 6'd8, 1'b0, 1'b0, 1'b0);
        check("op_count_1", 32'(op_count), 32'd1);
        op("sub_2_5", 3'b111, 6'd2, 6'd5, 6'h3D, 1'b0, 1'b1, 1'b0);
        op("sub_9_9", 3'b111, 6'd9, 6'd9, 6'h00, 1'b1, 1'b0, 1'b0);
        op("add_31_1", 3'b110, 6'd31, 6'd1, sat_pos, 1'b0, 1'b0, 1'b1);
        op("add_63_1", 3'b110, 6'd63, 6'd1, 6'h00, 1'b1, 1'b1, 1'b0);
        check("op_count_5", 32'(op_count), 32'd5);
        check("cnt2_wrap", 32'(op_count2), 32'd1);
        op("sub_m32_1", 3'b111, 6'h20, 6'd1, sat_neg, 1'b0, 1'b0, 1'b1);
        op("gt_7_3", 3'b100, 6'd7, 6'd3, 6'd1, 1'b0, 1'b0, 1'b0);
        op("gt_3_7", 3'b100, 6'd3, 6'd7, 6'd0, 1'b1, 1'b0, 1'b0);
        op("neg_1", 3'b010, 6'd1, 6'd0, 6'h3F, 1'b0, 1'b0, 1'b0);
        check("op_count_9", 32'(op_count), 32'd9);

        // Streaming: out_ready low for cycles 4..6.
        sent = 0;
        recv = 0;
        held = 6'h00;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 8);
            fxn_code  = 3'(sent);
            a         = 6'd12;
            b         = 6'd5;
            #1;
            if (!out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                if (cyc > 4) check("stall_hold", 32'(result), 32'(held));
                held = result;
            end
            if (out_valid) begin
                check($sformatf("stream_%0d", recv), 32'({result, flag_z, flag_c, flag_v}),
                      32'(stream_exp[recv]));
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stream_recv", 32'(recv), 32'd8);
        #1;
        check("stream_no_dup", 32'(out_valid), 32'd0);
        check("op_count_17", 32'(op_count), 32'd17);

        // Fill both stages with a stalled consumer, then reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        fxn_code  = 3'b110;
        a         = 6'd1;
        b         = 6'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        op("post_rst_xor", 3'b101, 6'h2A, 6'h0F, 6'h25, 1'b0, 1'b0, 1'b0);
        check("post_rst_count", 32'(op_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
